// File: rtl/gc_issue_scheduler_pkg.sv
// Shared definitions for the garbled-circuit engine: pipeline depth and
// the issue-scheduler state encoding.
package gc_issue_scheduler_pkg;

  // Garbling pipeline depth (AES rounds) from issue to write-back.
  localparam int NR_AES = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } gc_state_e;

endpackage

// File: rtl/gc_issue_scheduler_scoreboard.sv
// In-flight gate tracker: a D-deep shift register of {valid, gid} that
// advances every cycle. It answers two operand queries against every
// entry (the retiring tail included) and exposes the tail for write-back.
module gc_scoreboard
  import gc_issue_scheduler_pkg::*;
#(
  parameter int S = 20,
  parameter int D = NR_AES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic [S-1:0] push_gid,
  input  logic [S-1:0] q0_gid,
  input  logic [S-1:0] q1_gid,
  output logic         hit0,
  output logic         hit1,
  output logic         tail_valid,
  output logic [S-1:0] tail_gid
);

  logic [D-1:0] valid_r;
  logic [S-1:0] gid_r [D];

  // Shift the pipeline by one stage per cycle; clr drops every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= '0;
      for (int i = 0; i < D; i++) gid_r[i] <= '0;
    end else begin
      valid_r[0] <= push & ~clr;
      gid_r[0]   <= push_gid;
      for (int i = 1; i < D; i++) begin
        valid_r[i] <= valid_r[i-1] & ~clr;
        gid_r[i]   <= gid_r[i-1];
      end
    end
  end

  // Match both operand queries against all valid entries.
  always_comb begin
    hit0 = 1'b0;
    hit1 = 1'b0;
    for (int i = 0; i < D; i++) begin
      hit0 = hit0 | (valid_r[i] & (gid_r[i] == q0_gid));
      hit1 = hit1 | (valid_r[i] & (gid_r[i] == q1_gid));
    end
  end

  assign tail_valid = valid_r[D-1];
  assign tail_gid   = gid_r[D-1];

endmodule

// File: rtl/gc_issue_scheduler.sv
// In-order gate issue scheduler for the garbling pipeline. Offers gates
// 0..gate_count-1 one at a time, holds a gate while any operand it reads
// is still being produced inside the pipeline, and reports retirement.
module gc_issue_scheduler
  import gc_issue_scheduler_pkg::*;
#(
  parameter int S = 20,
  parameter int D = NR_AES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [S-1:0] gate_count,
  input  logic [S-1:0] input_size,
  input  logic         in0F,
  input  logic         in1F,
  input  logic [S-1:0] in0,
  input  logic [S-1:0] in1,
  output logic [S-1:0] gid,
  output logic         issue,
  output logic         stall,
  output logic         wb_en,
  output logic [S-1:0] wb_gid,
  output logic         busy,
  output logic         done,
  output logic [S-1:0] stall_cnt
);

  gc_state_e    state_r;
  logic [S-1:0] gid_r;
  logic [S-1:0] gate_count_r;
  logic [S-1:0] stall_cnt_r;
  logic         busy_r;
  logic         done_r;

  logic         hit0_s, hit1_s, hazard_s, run_s, issue_s, stall_s;
  logic         start_run_s, tail_valid_s;
  logic [S-1:0] q0_s, q1_s, tail_gid_s, last_gid_s;

  function automatic logic [S-1:0] sat_inc(input logic [S-1:0] v);
    if (v == {S{1'b1}}) sat_inc = v;
    else                sat_inc = v + S'(1);
  endfunction

  // Operand wire index -> producing gate index (gate outputs follow inputs).
  assign q0_s        = in0 - input_size;
  assign q1_s        = in1 - input_size;
  assign hazard_s    = (~in0F & hit0_s) | (~in1F & hit1_s);
  assign run_s       = (state_r == ST_RUN);
  assign issue_s     = run_s & ~hazard_s;
  assign stall_s     = run_s & hazard_s;
  assign start_run_s = (state_r == ST_IDLE) & start & (gate_count != '0);
  assign last_gid_s  = gate_count_r - S'(1);

  gc_scoreboard #(.S(S), .D(D)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_run_s),
    .push      (issue_s),
    .push_gid  (gid_r),
    .q0_gid    (q0_s),
    .q1_gid    (q1_s),
    .hit0      (hit0_s),
    .hit1      (hit1_s),
    .tail_valid(tail_valid_s),
    .tail_gid  (tail_gid_s)
  );

  // Run-control FSM with registered gid, stall counter, busy and done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      gid_r        <= '0;
      gate_count_r <= '0;
      stall_cnt_r  <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start && (gate_count != '0)) begin
            state_r      <= ST_RUN;
            gid_r        <= '0;
            stall_cnt_r  <= '0;
            gate_count_r <= gate_count;
            busy_r       <= 1'b1;
          end else if (start) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_RUN: begin
          if (issue_s && (gid_r == last_gid_s)) begin
            state_r <= ST_DRAIN;
          end else if (issue_s) begin
            gid_r <= gid_r + S'(1);
          end else begin
            stall_cnt_r <= sat_inc(stall_cnt_r);
          end
        end
        ST_DRAIN: begin
          // Gates retire in issue order, so the last gate leaving empties the pipe.
          if (tail_valid_s && (tail_gid_s == last_gid_s)) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
          end else begin
            busy_r <= 1'b1;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign gid       = gid_r;
  assign issue     = issue_s;
  assign stall     = stall_s;
  assign wb_en     = tail_valid_s;
  assign wb_gid    = tail_gid_s;
  assign busy      = busy_r;
  assign done      = done_r;
  assign stall_cnt = stall_cnt_r;

endmodule
